// File: rtl/dot_product_accumulator_if.sv
// Handshake bundle between the multiplier front end, the accumulator and
// the downstream result consumer.
interface dot_product_accumulator_if #(
  parameter int unsigned ACC_W = 12
);
  logic             clr;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_product;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_ovf;
  logic [4:0]       term_cnt;

  // Accumulator side
  modport slave (
    input  clr, in_valid, in_product, out_ready,
    output in_ready, out_valid, out_sum, out_ovf, term_cnt
  );

  // Producer / consumer side
  modport master (
    output clr, in_valid, in_product, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf, term_cnt
  );
endinterface

// File: rtl/dot_product_accumulator.sv
// Sums groups of N_TERMS unsigned 8-bit products into an ACC_W-bit result
// with a sticky overflow flag, presented on a valid/ready output.
module dot_product_accumulator #(
  parameter int unsigned N_TERMS = 4,
  parameter int unsigned ACC_W   = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  dot_product_accumulator_if.slave   bus
);

  typedef enum logic {ST_ACC, ST_DONE} state_t;

  localparam logic [4:0] LAST = 5'(N_TERMS - 1);

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_sum_q, out_sum_d;
  logic             out_ovf_q, out_ovf_d;

  logic             in_ready;
  logic             accept;
  logic [ACC_W:0]   sum;

  // Ready, accept qualification and the widened add (bit ACC_W is the carry)
  always_comb begin
    in_ready = (state_q == ST_ACC) | bus.out_ready;
    accept   = bus.in_valid & in_ready & ~bus.clr;
    sum      = {1'b0, acc_q} + {{(ACC_W - 7){1'b0}}, bus.in_product};
  end

  // Next-state logic; acc and cnt are always zero in DONE, so a product
  // accepted there flows through the same path as a first term in ACC,
  // which also covers the N_TERMS==1 back-to-back completion case.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_ovf_d   = out_ovf_q;

    if (state_q == ST_DONE && bus.out_ready) begin
      out_valid_d = 1'b0;
      state_d     = ST_ACC;
    end

    if (bus.clr) begin
      acc_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (accept) begin
      if (cnt_q == LAST) begin
        out_sum_d   = sum[ACC_W-1:0];
        out_ovf_d   = ovf_q | sum[ACC_W];
        out_valid_d = 1'b1;
        acc_d       = '0;
        cnt_d       = '0;
        ovf_d       = 1'b0;
        state_d     = ST_DONE;
      end else begin
        acc_d = sum[ACC_W-1:0];
        cnt_d = cnt_q + 5'd1;
        ovf_d = ovf_q | sum[ACC_W];
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  // Output drive
  always_comb begin
    bus.in_ready  = in_ready;
    bus.out_valid = out_valid_q;
    bus.out_sum   = out_sum_q;
    bus.out_ovf   = out_ovf_q;
    bus.term_cnt  = cnt_q;
  end

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Three configurations (4x12, 8x10, 1x12) driven with shared stimulus and
// checked against a group-level arithmetic model.
module tb_dot_product_accumulator;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr, in_valid, out_ready;
  logic [7:0] in_product;

  always #5 clk = ~clk;

  dot_product_accumulator_if #(.ACC_W(12)) if0 ();
  dot_product_accumulator_if #(.ACC_W(10)) if1 ();
  dot_product_accumulator_if #(.ACC_W(12)) if2 ();

  dot_product_accumulator #(.N_TERMS(4), .ACC_W(12)) u0 (.clk(clk), .rst(rst), .bus(if0));
  dot_product_accumulator #(.N_TERMS(8), .ACC_W(10)) u1 (.clk(clk), .rst(rst), .bus(if1));
  dot_product_accumulator #(.N_TERMS(1), .ACC_W(12)) u2 (.clk(clk), .rst(rst), .bus(if2));

  assign if0.clr = clr;  assign if0.in_valid = in_valid;
  assign if0.in_product = in_product;  assign if0.out_ready = out_ready;
  assign if1.clr = clr;  assign if1.in_valid = in_valid;
  assign if1.in_product = in_product;  assign if1.out_ready = out_ready;
  assign if2.clr = clr;  assign if2.in_valid = in_valid;
  assign if2.in_product = in_product;  assign if2.out_ready = out_ready;

  logic [15:0] d_sum [3];
  logic        d_vld [3];
  logic        d_rdy [3];
  logic        d_ovf [3];
  logic [4:0]  d_cnt [3];

  assign d_sum[0] = 16'(if0.out_sum);  assign d_sum[1] = 16'(if1.out_sum);
  assign d_sum[2] = 16'(if2.out_sum);
  assign d_vld[0] = if0.out_valid;  assign d_vld[1] = if1.out_valid;
  assign d_vld[2] = if2.out_valid;
  assign d_rdy[0] = if0.in_ready;  assign d_rdy[1] = if1.in_ready;
  assign d_rdy[2] = if2.in_ready;
  assign d_ovf[0] = if0.out_ovf;  assign d_ovf[1] = if1.out_ovf;
  assign d_ovf[2] = if2.out_ovf;
  assign d_cnt[0] = if0.term_cnt;  assign d_cnt[1] = if1.term_cnt;
  assign d_cnt[2] = if2.term_cnt;

  // Reference model: true (unbounded) group sum, wrapped only at completion
  int NT [3] = '{4, 8, 1};
  int WB [3] = '{12, 10, 12};
  bit m_pend [3];
  int m_sum  [3];
  bit m_ovf  [3];
  int m_cnt  [3];
  int m_part [3];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_pend[k] = 0; m_sum[k] = 0; m_ovf[k] = 0; m_cnt[k] = 0; m_part[k] = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      bit rdy;
      rdy = !m_pend[k] || out_ready;
      if (m_pend[k] && out_ready) m_pend[k] = 0;
      if (clr) begin
        m_part[k] = 0;
        m_cnt[k]  = 0;
      end else if (in_valid && rdy) begin
        m_part[k] += int'(in_product);
        m_cnt[k]++;
        if (m_cnt[k] == NT[k]) begin
          m_pend[k] = 1;
          m_sum[k]  = m_part[k] % (1 << WB[k]);
          m_ovf[k]  = m_part[k] >= (1 << WB[k]);
          m_part[k] = 0;
          m_cnt[k]  = 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("in_ready[%0d]", k), 32'(d_rdy[k]), 32'(!m_pend[k] || out_ready));
      chk($sformatf("out_valid[%0d]", k), 32'(d_vld[k]), 32'(m_pend[k]));
      chk($sformatf("term_cnt[%0d]", k), 32'(d_cnt[k]), 32'(m_cnt[k]));
      if (m_pend[k]) begin
        chk($sformatf("out_sum[%0d]", k), 32'(d_sum[k]), 32'(m_sum[k]));
        chk($sformatf("out_ovf[%0d]", k), 32'(d_ovf[k]), 32'(m_ovf[k]));
      end
    end
  endtask

  // One clock: drive, check pre-edge state at negedge, advance model at edge
  task automatic step(input bit v, input int p, input bit r, input bit c);
    in_valid   = v;
    in_product = 8'(p);
    out_ready  = r;
    clr        = c;
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Asynchronous reset pulse, asserted between clock edges
  task automatic do_rst();
    in_valid = 1'b1; in_product = 8'd200; out_ready = 1'b1; clr = 1'b0;
    rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_vld[%0d]", k), 32'(d_vld[k]), 0);
      chk($sformatf("rst_sum[%0d]", k), 32'(d_sum[k]), 0);
      chk($sformatf("rst_ovf[%0d]", k), 32'(d_ovf[k]), 0);
      chk($sformatf("rst_cnt[%0d]", k), 32'(d_cnt[k]), 0);
      chk($sformatf("rst_rdy[%0d]", k), 32'(d_rdy[k]), 1);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_product = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Full-scale sum
    for (int i = 0; i < 4; i++) step(1, 225, 1, 0);
    chk("full_vld", 32'(d_vld[0]), 1);
    chk("full_sum", 32'(d_sum[0]), 900);
    chk("full_ovf", 32'(d_ovf[0]), 0);

    // Overflow wrap on the 8x10 instance, then a clean group
    do_rst();
    for (int i = 0; i < 8; i++) step(1, 225, 1, 0);
    chk("wrap_sum", 32'(d_sum[1]), 776);
    chk("wrap_ovf", 32'(d_ovf[1]), 1);
    for (int i = 0; i < 8; i++) step(1, 1, 1, 0);
    chk("post_wrap_sum", 32'(d_sum[1]), 8);
    chk("post_wrap_ovf", 32'(d_ovf[1]), 0);

    // Backpressure
    do_rst();
    for (int i = 1; i <= 4; i++) step(1, i, 1, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 99, 0, 0);
      chk("bp_rdy", 32'(d_rdy[0]), 0);
      chk("bp_sum", 32'(d_sum[0]), 10);
      chk("bp_vld", 32'(d_vld[0]), 1);
    end
    step(1, 7, 1, 0);
    chk("bp_restart_cnt", 32'(d_cnt[0]), 1);
    chk("bp_restart_vld", 32'(d_vld[0]), 0);
    for (int i = 0; i < 3; i++) step(1, 1, 1, 0);
    chk("bp_next_sum", 32'(d_sum[0]), 10);

    // Streaming
    do_rst();
    for (int i = 0; i < 12; i++) begin
      step(1, i, 1, 0);
      chk("stream_rdy", 32'(d_rdy[0]), 1);
      if (i == 3)  chk("stream_sum0", 32'(d_sum[0]), 6);
      if (i == 7)  chk("stream_sum1", 32'(d_sum[0]), 22);
      if (i == 11) chk("stream_sum2", 32'(d_sum[0]), 38);
    end

    // clr mid-group, including a product dropped alongside clr
    do_rst();
    step(1, 50, 1, 0);
    step(1, 60, 1, 0);
    step(1, 77, 1, 1);
    chk("clr_cnt", 32'(d_cnt[0]), 0);
    for (int i = 1; i <= 4; i++) step(1, i, 1, 0);
    chk("clr_sum", 32'(d_sum[0]), 10);

    // Async reset after two accepts, then a full group
    do_rst();
    step(1, 5, 1, 0);
    step(1, 6, 1, 0);
    do_rst();
    for (int i = 0; i < 4; i++) step(1, 3, 1, 0);
    chk("rst_group_sum", 32'(d_sum[0]), 12);

    // Single-term groups back to back
    do_rst();
    step(1, 9, 1, 0);
    chk("n1_sum9", 32'(d_sum[2]), 9);
    step(1, 8, 1, 0);
    chk("n1_sum8", 32'(d_sum[2]), 8);
    chk("n1_vld8", 32'(d_vld[2]), 1);
    step(1, 7, 1, 0);
    chk("n1_sum7", 32'(d_sum[2]), 7);
    chk("n1_vld7", 32'(d_vld[2]), 1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) do_rst();
      else step(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 225)),
                1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 19) == 0));
    end
    step(0, 0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
